// File: rtl/pid_seq.sv
// pid_seq: four-state sequencer that turns one heading sample into a saturated PID command,
// strobing the external integrator between the error and derivative stages.
module pid_seq #(
   parameter logic [3:0] P_COEFF = 4'd3,
   parameter logic [4:0] D_COEFF = 5'd5
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        moving,
   input  logic        hdng_vld,
   input  logic [11:0] heading,
   input  logic [11:0] dsrd_hdng,
   input  logic [11:0] I_term,
   output logic [9:0]  err_sat,
   output logic        int_en,
   output logic [13:0] PID,
   output logic        pid_vld,
   output logic        busy,
   output logic        overrun
);
   typedef enum logic [1:0] {IDLE, PTERM, DTERM, SUM} state_t;
   state_t state_q, state_d;
   logic signed [9:0]  err_sat_q, err_sat_d, prev_err_q, prev_err_d;
   logic signed [13:0] p_q, p_d, d_q, d_d, pid_q, pid_d;
   logic               pid_vld_q, pid_vld_d, overrun_q, overrun_d;
   logic signed [11:0] diff;
   logic signed [9:0]  err_clip;
   logic signed [10:0] dd;
   logic signed [7:0]  dd_clip;
   logic signed [15:0] sum;
   logic signed [13:0] sum_clip;
   // modulo-4096 subtraction makes the compass wrap fall out as a signed 12-bit error
   assign diff     = heading - dsrd_hdng;
   assign err_clip = diff > 12'sd511 ? 10'sd511 : diff < -12'sd512 ? 10'sh200 : diff[9:0];
   assign dd       = {err_sat_q[9], err_sat_q} - {prev_err_q[9], prev_err_q};
   assign dd_clip  = dd > 11'sd127 ? 8'sd127 : dd < -11'sd128 ? 8'sh80 : dd[7:0];
   assign sum      = 16'(p_q) + 16'($signed(I_term)) + 16'(d_q);
   assign sum_clip = sum > 16'sd8191 ? 14'sd8191 : sum < -16'sd8192 ? 14'sh2000 : sum[13:0];
   always_comb begin
      state_d    = state_q;
      err_sat_d  = err_sat_q;
      prev_err_d = prev_err_q;
      p_d        = p_q;
      d_d        = d_q;
      pid_d      = pid_q;
      pid_vld_d  = 1'b0;
      overrun_d  = hdng_vld & moving & (state_q != IDLE);
      if (!moving) begin
         state_d    = IDLE;
         err_sat_d  = '0;
         prev_err_d = '0;
         p_d        = '0;
         d_d        = '0;
         pid_d      = '0;
      end else begin
         case (state_q)
            IDLE: if (hdng_vld) begin
               err_sat_d = err_clip;
               state_d   = PTERM;
            end
            PTERM: begin
               p_d     = 14'(err_sat_q) * 14'($signed({1'b0, P_COEFF}));
               state_d = DTERM;
            end
            DTERM: begin
               d_d     = 14'(dd_clip) * 14'($signed({1'b0, D_COEFF}));
               state_d = SUM;
            end
            SUM: begin
               pid_d      = sum_clip;
               pid_vld_d  = 1'b1;
               prev_err_d = err_sat_q;
               state_d    = IDLE;
            end
         endcase
      end
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         err_sat_q  <= '0;
         prev_err_q <= '0;
         p_q        <= '0;
         d_q        <= '0;
         pid_q      <= '0;
         pid_vld_q  <= 1'b0;
         overrun_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         err_sat_q  <= err_sat_d;
         prev_err_q <= prev_err_d;
         p_q        <= p_d;
         d_q        <= d_d;
         pid_q      <= pid_d;
         pid_vld_q  <= pid_vld_d;
         overrun_q  <= overrun_d;
      end
   end
   assign err_sat = err_sat_q;
   assign PID     = pid_q;
   assign pid_vld = pid_vld_q;
   assign overrun = overrun_q;
   assign busy    = state_q != IDLE;
   assign int_en  = state_q == PTERM;
endmodule

// File: tb/tb_pid_seq.sv
// tb_pid_seq: randomized and directed checks of pid_seq against an arithmetic reference model.
module tb_pid_seq;
   logic        clk, rst_n, moving, hdng_vld;
   logic [11:0] heading, dsrd_hdng, I_term;
   logic [9:0]  err_sat;
   logic [13:0] PID;
   logic        int_en, pid_vld, busy, overrun;
   int          n_chk, n_fail, prev_err_m, last_pid;
   pid_seq dut (
      .clk(clk), .rst_n(rst_n), .moving(moving), .hdng_vld(hdng_vld),
      .heading(heading), .dsrd_hdng(dsrd_hdng), .I_term(I_term),
      .err_sat(err_sat), .int_en(int_en), .PID(PID), .pid_vld(pid_vld),
      .busy(busy), .overrun(overrun)
   );
   initial clk = 1'b0;
   always #5 clk = ~clk;
   task automatic check(input string tag, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
      end
   endtask
   function automatic int clip(input int v, input int lo, input int hi);
      return v < lo ? lo : (v > hi ? hi : v);
   endfunction
   function automatic int s12(input int v);
      int w;
      w = v & 'hFFF;
      return w >= 2048 ? w - 4096 : w;
   endfunction
   function automatic void model(input int h, input int d, input int i, input int pe,
                                 output int e, output int pid);
      e   = clip(s12(h - d), -512, 511);
      pid = clip(e * 3 + s12(i) + clip(e - pe, -128, 127) * 5, -8192, 8191);
   endfunction
   // One sample: ovr_at pulses hdng_vld in that busy cycle, ab_at drops moving in that cycle.
   task automatic run(input logic [11:0] h, input logic [11:0] d, input logic [11:0] i,
                      input int ovr_at, input int ab_at);
      int e, pe;
      model(int'(h), int'(d), int'(i), prev_err_m, e, pe);
      heading = h; dsrd_hdng = d; I_term = i; hdng_vld = 1'b1;
      for (int c = 1; c <= 4; c++) begin
         @(negedge clk);
         hdng_vld = 1'b0;
         moving   = 1'b1;
         if (ab_at != 0 && c == ab_at + 1) begin
            check("abort_busy", busy, 0);
            check("abort_pid", $signed(PID), 0);
            check("abort_err", $signed(err_sat), 0);
            check("abort_vld", pid_vld, 0);
            prev_err_m = 0;
            last_pid   = 0;
            @(negedge clk);
            check("abort_novld", pid_vld, 0);
            check("abort_noint", int_en, 0);
            return;
         end
         check("busy", busy, int'(c < 4));
         check("int_en", int_en, int'(c == 1));
         check("pid_vld", pid_vld, int'(c == 4));
         check("overrun", overrun, int'(ovr_at != 0 && c == ovr_at + 1));
         check("err_sat", $signed(err_sat), e);
         check("pid", $signed(PID), c == 4 ? pe : last_pid);
         if (c == ovr_at) begin
            hdng_vld = 1'b1;
            heading  = 12'($urandom);
         end
         if (c == ab_at) moving = 1'b0;
      end
      prev_err_m = e;
      last_pid   = pe;
   endtask
   // moving low in IDLE with a heading pulse: ignored, no overrun, history cleared
   task automatic clear();
      moving = 1'b0; hdng_vld = 1'b1;
      @(negedge clk);
      check("still_busy", busy, 0);
      check("still_ovr", overrun, 0);
      check("still_err", $signed(err_sat), 0);
      check("still_pid", $signed(PID), 0);
      moving = 1'b1; hdng_vld = 1'b0;
      prev_err_m = 0;
      last_pid   = 0;
   endtask
   initial begin
      logic [11:0] rh, rd, ri;
      int mode, ovr, ab;
      n_chk = 0; n_fail = 0; prev_err_m = 0; last_pid = 0;
      rst_n = 1'b0; moving = 1'b1; hdng_vld = 1'b0;
      heading = '0; dsrd_hdng = '0; I_term = '0;
      repeat (2) @(negedge clk);
      check("rst_err", $signed(err_sat), 0);
      check("rst_pid", $signed(PID), 0);
      check("rst_busy", busy, 0);
      check("rst_int", int_en, 0);
      check("rst_vld", pid_vld, 0);
      check("rst_ovr", overrun, 0);
      rst_n = 1'b1;
      @(negedge clk);
      run(12'h100, 12'h0F0, 12'd1, 0, 0);
      check("basic_err", $signed(err_sat), 16);
      check("basic_pid", $signed(PID), 129);
      clear();
      run(12'h400, 12'h000, 12'd31, 0, 0);
      check("sat_err", $signed(err_sat), 511);
      check("sat_pid", $signed(PID), 2199);
      clear();
      run(12'h400, 12'h000, 12'h7FF, 0, 0);
      check("sat_pid_imax", $signed(PID), 4215);
      clear();
      run(12'hC00, 12'h000, 12'h800, 0, 0);
      check("sat_pid_neg", $signed(PID), -4224);
      clear();
      run(12'h010, 12'hFF0, 12'd0, 0, 0);
      check("wrap_pos", $signed(err_sat), 32);
      run(12'hFF0, 12'h010, 12'd0, 0, 0);
      check("wrap_neg", $signed(err_sat), -32);
      clear();
      run(12'h110, 12'h100, 12'd0, 0, 0);
      run(12'h114, 12'h100, 12'd0, 0, 0);
      check("deriv_pid", $signed(PID), 80);
      run(12'h120, 12'h100, 12'd5, 1, 0);
      run(12'h130, 12'h100, 12'd7, 0, 2);
      run(12'h108, 12'h100, 12'd0, 0, 0);
      check("post_abort_pid", $signed(PID), 64);
      heading = 12'h100; dsrd_hdng = 12'h0F0; I_term = 12'd1; hdng_vld = 1'b1;
      @(negedge clk);
      hdng_vld = 1'b0;
      repeat (2) @(negedge clk);
      check("sum_busy", busy, 1);
      #2 rst_n = 1'b0;
      #1;
      check("arst_err", $signed(err_sat), 0);
      check("arst_pid", $signed(PID), 0);
      check("arst_busy", busy, 0);
      check("arst_int", int_en, 0);
      check("arst_vld", pid_vld, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("arst_novld", pid_vld, 0);
      prev_err_m = 0;
      last_pid   = 0;
      for (int n = 0; n < 60; n++) begin
         mode = int'($urandom_range(0, 9));
         rh   = 12'($urandom);
         rd   = (mode == 0) ? 12'($urandom) : 12'(int'(rh) + int'($urandom_range(0, 1400)) - 700);
         ri   = 12'($urandom);
         ovr  = (mode == 1) ? int'($urandom_range(1, 3)) : 0;
         ab   = (mode == 2) ? int'($urandom_range(1, 3)) : 0;
         run(rh, rd, ri, ovr, ab);
         if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
         if (mode == 3) clear();
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
